// File: rtl/snd_pkg.sv
// Shared definitions for the sound-channel control blocks: frame-sequencer constants,
// register bit-field positions and the envelope configuration record.
package snd_pkg;

    localparam int LEN_BITS_DEF       = 6;
    localparam int ENV_FRAME_STEP_DEF = 7;

    // Bit i set means frame step i clocks the length counters (even steps only).
    localparam logic [7:0] LEN_STEPS = 8'b0101_0101;

    localparam int NRX2_VOL_MSB    = 7;
    localparam int NRX2_VOL_LSB    = 4;
    localparam int NRX2_DIR_BIT    = 3;
    localparam int NRX2_PER_MSB    = 2;
    localparam int NRX2_PER_LSB    = 0;
    localparam int NRX4_TRIG_BIT   = 7;
    localparam int NRX4_LEN_EN_BIT = 6;

    typedef struct packed {
        logic [3:0] vol;
        logic       inc;
        logic [2:0] period;
    } env_cfg_t;

    function automatic env_cfg_t decode_nrx2(input logic [7:0] data);
        env_cfg_t cfg;
        cfg.vol    = data[NRX2_VOL_MSB:NRX2_VOL_LSB];
        cfg.inc    = data[NRX2_DIR_BIT];
        cfg.period = data[NRX2_PER_MSB:NRX2_PER_LSB];
        return cfg;
    endfunction

    // The DAC is powered whenever any of the upper five envelope-register bits is set.
    function automatic logic dac_enabled(input env_cfg_t cfg);
        return (cfg.vol != 4'd0) || cfg.inc;
    endfunction

endpackage

// File: rtl/ch4_envelope_sequencer_if.sv
// Register-write bus into channel 4: one write strobe plus data byte per register.
interface ch4_envelope_sequencer_if;

    logic       nr41_wr;
    logic [7:0] nr41_data;
    logic       nr42_wr;
    logic [7:0] nr42_data;
    logic       nr44_wr;
    logic [7:0] nr44_data;

    modport master (
        output nr41_wr, nr41_data,
        output nr42_wr, nr42_data,
        output nr44_wr, nr44_data
    );

    modport slave (
        input nr41_wr, nr41_data,
        input nr42_wr, nr42_data,
        input nr44_wr, nr44_data
    );

endinterface

// File: rtl/ch4_envelope_sequencer_frame_sequencer.sv
// 8-step frame sequencer: advances on the 512 Hz strobe and emits registered length and
// envelope strobes, plus same-cycle fire flags so the consumer acts on the strobe edge.
module frame_sequencer
    import snd_pkg::*;
#(
    parameter int ENV_FRAME_STEP = ENV_FRAME_STEP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_512,
    output logic [2:0] frame_step,
    output logic       len_tick,
    output logic       env_tick,
    output logic       len_fire,
    output logic       env_fire
);

    logic [2:0] step_next;

    always_comb begin
        step_next = frame_step + 3'd1;
        len_fire  = tick_512 && LEN_STEPS[step_next];
        env_fire  = tick_512 && (step_next == 3'(ENV_FRAME_STEP));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_step <= 3'd0;
            len_tick   <= 1'b0;
            env_tick   <= 1'b0;
        end else begin
            len_tick <= len_fire;
            env_tick <= env_fire;
            if (tick_512) begin
                frame_step <= step_next;
            end
        end
    end

endmodule

// File: rtl/ch4_envelope_sequencer.sv
// Channel 4 (noise) control: length counter, trigger handling, DAC gating and envelope
// stepping, all driven by register write strobes and the frame sequencer.
module ch4_envelope_sequencer
    import snd_pkg::*;
#(
    parameter int LEN_BITS       = LEN_BITS_DEF,
    parameter int ENV_FRAME_STEP = ENV_FRAME_STEP_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick_512,
    ch4_envelope_sequencer_if.slave   regs,
    output logic [3:0]                volume_level,
    output logic                      channel_on,
    output logic [2:0]                frame_step,
    output logic                      len_tick,
    output logic                      env_tick
);

    localparam int                LEN_W   = LEN_BITS + 1;
    localparam logic [LEN_W-1:0]  LEN_MAX = {1'b1, {LEN_BITS{1'b0}}};
    localparam logic [LEN_W-1:0]  LEN_ONE = {{LEN_BITS{1'b0}}, 1'b1};

    logic             len_fire;
    logic             env_fire;

    logic [LEN_W-1:0] len_counter, len_next;
    logic             len_en, len_en_next;
    env_cfg_t         shadow, shadow_next;
    logic [2:0]       env_period, env_period_next;
    logic             env_inc, env_inc_next;
    logic [3:0]       env_timer, timer_next;
    logic [3:0]       volume, vol_next;
    logic             on_next;
    logic             trigger;

    logic             unused_reg_bits;
    assign unused_reg_bits = ^{regs.nr41_data[7:LEN_BITS], regs.nr44_data[NRX4_LEN_EN_BIT-1:0]};

    frame_sequencer #(
        .ENV_FRAME_STEP(ENV_FRAME_STEP)
    ) u_frame_sequencer (
        .clock     (clock),
        .reset     (reset),
        .tick_512  (tick_512),
        .frame_step(frame_step),
        .len_tick  (len_tick),
        .env_tick  (env_tick),
        .len_fire  (len_fire),
        .env_fire  (env_fire)
    );

    // A trigger consumes any coincident length/envelope clock; a length load beats a length clock.
    always_comb begin
        shadow_next     = shadow;
        len_next        = len_counter;
        len_en_next     = len_en;
        env_period_next = env_period;
        env_inc_next    = env_inc;
        timer_next      = env_timer;
        vol_next        = volume;
        on_next         = channel_on;

        if (regs.nr42_wr) begin
            shadow_next = decode_nrx2(regs.nr42_data);
        end

        trigger = regs.nr44_wr && regs.nr44_data[NRX4_TRIG_BIT];

        if (regs.nr41_wr) begin
            len_next = LEN_MAX - {1'b0, regs.nr41_data[LEN_BITS-1:0]};
        end else if (trigger) begin
            if (len_counter == '0) begin
                len_next = LEN_MAX;
            end
        end else if (len_fire && len_en && (len_counter != '0)) begin
            len_next = len_counter - LEN_ONE;
            if (len_counter == LEN_ONE) begin
                on_next = 1'b0;
            end
        end

        if (regs.nr44_wr) begin
            len_en_next = regs.nr44_data[NRX4_LEN_EN_BIT];
        end

        if (trigger) begin
            on_next         = 1'b1;
            vol_next        = shadow_next.vol;
            env_period_next = shadow_next.period;
            env_inc_next    = shadow_next.inc;
            timer_next      = (shadow_next.period == 3'd0) ? 4'd8 : {1'b0, shadow_next.period};
        end else if (env_fire && (env_period != 3'd0)) begin
            if (env_timer <= 4'd1) begin
                timer_next = {1'b0, env_period};
                if (env_inc && (volume != 4'd15)) begin
                    vol_next = volume + 4'd1;
                end else if (!env_inc && (volume != 4'd0)) begin
                    vol_next = volume - 4'd1;
                end
            end else begin
                timer_next = env_timer - 4'd1;
            end
        end

        if (!dac_enabled(shadow_next)) begin
            on_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_counter <= '0;
            len_en      <= 1'b0;
            shadow      <= '0;
            env_period  <= 3'd0;
            env_inc     <= 1'b0;
            env_timer   <= 4'd0;
            volume      <= 4'd0;
            channel_on  <= 1'b0;
        end else begin
            len_counter <= len_next;
            len_en      <= len_en_next;
            shadow      <= shadow_next;
            env_period  <= env_period_next;
            env_inc     <= env_inc_next;
            env_timer   <= timer_next;
            volume      <= vol_next;
            channel_on  <= on_next;
        end
    end

    assign volume_level = channel_on ? volume : 4'd0;

endmodule
